serial_encoder: RTL and testbench

SERIAL_ENCODER -- requirements
Module: serial_encoder

---
 rtl/serial_encoder.sv | 193 +++++++++++++++++++
 tb/tb_serial_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_encoder.sv
// ============================================================================
// Module   : serial_encoder
// Purpose  : Captures a one-hot or multi-hot input vector and streams out the
//            binary index of every set bit, lowest index first. Each index is
//            presented as one beat with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IN_WIDTH   width of the captured input vector
//   OUT_WIDTH  width of the binary index; IN_WIDTH must not exceed 2**OUT_WIDTH
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   input vector offered
//   in_ready   block is idle and can accept a vector this cycle
//   in         vector to encode; bit i set means index i pending
//   out_valid  index beat offered
//   out_ready  consumer accepts the beat
//   out        binary index of the lowest pending bit
//   out_last   current beat is the final pending bit
//   onehot     captured vector had exactly one bit set
//   zero_err   one-cycle pulse after an all-zero vector was accepted
// ============================================================================
`default_nettype none

module serial_encoder #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_last,
  output logic                 onehot,
  output logic                 zero_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (IN_WIDTH > (2 ** OUT_WIDTH)) begin : g_width_check
      $error("serial_encoder: IN_WIDTH exceeds the range of OUT_WIDTH");
    end
    if (IN_WIDTH < 1) begin : g_min_width_check
      $error("serial_encoder: IN_WIDTH must be at least 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]          c_idle = 1'b0;
  localparam logic [0:0]          c_busy = 1'b1;
  localparam logic [IN_WIDTH-1:0] c_one  = IN_WIDTH'(1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [0:0]          r_state;
  logic [IN_WIDTH-1:0] r_mask;     // bits still waiting to be emitted
  logic                r_onehot;   // population of the captured vector was 1
  logic                r_zero_err; // all-zero vector accepted last cycle

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [0:0]           w_state_next;
  logic                 w_idle;
  logic                 w_busy;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_in_nonzero;
  logic                 w_in_single;
  logic                 w_mask_single;
  logic [IN_WIDTH-1:0]  w_mask_clear_low;
  logic [OUT_WIDTH-1:0] w_low_idx;

  assign w_idle = (r_state == c_idle);
  assign w_busy = (r_state == c_busy);

  // Both handshakes are qualified only by registered state, so neither
  // in_ready nor out_valid can depend combinationally on an input.
  assign w_in_fire  = in_valid  && w_idle;
  assign w_out_fire = out_ready && w_busy;

  // x & (x - 1) clears the lowest set bit; the result is zero exactly when
  // x has at most one bit set.
  assign w_in_nonzero     = (in != '0);
  assign w_in_single      = w_in_nonzero && ((in & (in - c_one)) == '0);
  assign w_mask_clear_low = r_mask & (r_mask - c_one);
  assign w_mask_single    = (r_mask != '0) && (w_mask_clear_low == '0);

  // Lowest-index priority encoder: scanning downward lets the lowest set
  // bit overwrite any higher match.
  always_comb begin
    w_low_idx = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low_idx = OUT_WIDTH'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        // An all-zero vector is consumed but produces no beats.
        if (w_in_fire && w_in_nonzero) begin
          w_state_next = c_busy;
        end
      end
      c_busy: begin
        if (w_out_fire && w_mask_single) begin
          w_state_next = c_idle;
        end
      end
      default: w_state_next = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (all terms come from registers)
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = w_idle;
    out_valid = w_busy;
    out       = '0;
    out_last  = 1'b0;
    onehot    = 1'b0;
    zero_err  = r_zero_err;
    if (w_busy) begin
      out      = w_low_idx;
      out_last = w_mask_single;
      onehot   = r_onehot;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // Input capture happens only in IDLE and beat retirement only in BUSY, so
  // the two update branches are mutually exclusive. The mask cannot change
  // while a beat is stalled, which keeps out/out_last stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_in_fire) begin
      r_mask <= in;
    end else if (w_out_fire) begin
      r_mask <= w_mask_clear_low;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_onehot <= 1'b0;
    end else if (w_in_fire && w_in_nonzero) begin
      r_onehot <= w_in_single;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= w_in_fire && !w_in_nonzero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_encoder.sv
// ============================================================================
// Module   : tb_serial_encoder
// Purpose  : Directed self-checking bench for serial_encoder (8-bit input,
//            3-bit index). Each step applies inputs, advances one clock and
//            compares the packed observation
//            {in_ready, out_valid, out[2:0], out_last, onehot, zero_err}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_encoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out;
  logic       out_last;
  logic       onehot;
  logic       zero_err;

  int nvec;
  int nerr;

  logic [7:0] obs;
  assign obs = {in_ready, out_valid, out, out_last, onehot, zero_err};

  serial_encoder #(
    .IN_WIDTH  (8),
    .OUT_WIDTH (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last),
    .onehot    (onehot),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected-value packing: {ir, ov, out[2:0], last, oh, ze}
  localparam logic [7:0] c_idle_obs = 8'b1_0_000_0_0_0;

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in        = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    nvec++;
    if (obs !== c_idle_obs) begin
      nerr++;
      $display("FAIL reset_held: got %b expected %b", obs, c_idle_obs);
    end
    reset = 1'b0;
    tick();
    nvec++;
    if (obs !== c_idle_obs) begin
      nerr++;
      $display("FAIL reset_release: got %b expected %b", obs, c_idle_obs);
    end
  endtask

  task automatic test_ignore();
    // in changes without in_valid: nothing may be captured.
    logic [7:0] vin [2]  = '{8'hFF, 8'h80};
    for (int k = 0; k < 2; k++) begin
      in_valid  = 1'b0;
      in        = vin[k];
      out_ready = 1'b1;
      tick();
      nvec++;
      if (obs !== c_idle_obs) begin
        nerr++;
        $display("FAIL ignore step %0d: got %b expected %b", k, obs, c_idle_obs);
      end
    end
  endtask

  task automatic test_single();
    logic       viv [2] = '{1'b1, 1'b0};
    logic [7:0] vin [2] = '{8'h04, 8'h00};
    logic [7:0] vex [2] = '{8'b0_1_010_1_1_0, c_idle_obs};
    for (int k = 0; k < 2; k++) begin
      in_valid  = viv[k];
      in        = vin[k];
      out_ready = 1'b1;
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL single step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  task automatic test_multi();
    logic       viv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] vin [4] = '{8'h92, 8'h00, 8'h00, 8'h00};
    logic [7:0] vex [4] = '{8'b0_1_001_0_0_0, 8'b0_1_100_0_0_0,
                            8'b0_1_111_1_0_0, c_idle_obs};
    for (int k = 0; k < 4; k++) begin
      in_valid  = viv[k];
      in        = vin[k];
      out_ready = 1'b1;
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL multi step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  task automatic test_endpoints();
    // Bit 0 and the top bit together.
    logic       viv [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] vin [3] = '{8'h81, 8'h00, 8'h00};
    logic [7:0] vex [3] = '{8'b0_1_000_0_0_0, 8'b0_1_111_1_0_0, c_idle_obs};
    for (int k = 0; k < 3; k++) begin
      in_valid  = viv[k];
      in        = vin[k];
      out_ready = 1'b1;
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL endpoints step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  task automatic test_stall();
    // in shows junk with in_valid low while BUSY; it must be ignored.
    logic       viv [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] vin [6] = '{8'h03, 8'hFF, 8'hAA, 8'h55, 8'h00, 8'h00};
    logic       vrd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] vex [6] = '{8'b0_1_000_0_0_0, 8'b0_1_000_0_0_0,
                            8'b0_1_000_0_0_0, 8'b0_1_000_0_0_0,
                            8'b0_1_001_1_0_0, c_idle_obs};
    for (int k = 0; k < 6; k++) begin
      in_valid  = viv[k];
      in        = vin[k];
      out_ready = vrd[k];
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL stall step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  task automatic test_zero();
    logic       viv [2] = '{1'b1, 1'b0};
    logic [7:0] vex [2] = '{8'b1_0_000_0_0_1, c_idle_obs};
    for (int k = 0; k < 2; k++) begin
      in_valid  = viv[k];
      in        = 8'h00;
      out_ready = 1'b1;
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL zero step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    in_valid  = 1'b1;
    in        = 8'hF0;
    out_ready = 1'b1;
    tick();
    nvec++;
    if (obs !== 8'b0_1_100_0_0_0) begin
      nerr++;
      $display("FAIL rstmid_first: got %b expected %b", obs, 8'b0_1_100_0_0_0);
    end
    in_valid = 1'b0;
    in       = 8'h00;
    reset    = 1'b1;
    #1;
    // No clock edge since reset rose: outputs must already be cleared.
    nvec++;
    if (obs !== c_idle_obs) begin
      nerr++;
      $display("FAIL rstmid_async: got %b expected %b", obs, c_idle_obs);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++;
      if (obs !== c_idle_obs) begin
        nerr++;
        $display("FAIL rstmid_after step %0d: got %b expected %b", k, obs, c_idle_obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Second vector is held during BUSY and must wait for IDLE.
    logic       viv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] vin [5] = '{8'h80, 8'h01, 8'h01, 8'h01, 8'h00};
    logic       vrd [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] vex [5] = '{8'b0_1_111_1_1_0, 8'b0_1_111_1_1_0,
                            c_idle_obs, 8'b0_1_000_1_1_0, c_idle_obs};
    for (int k = 0; k < 5; k++) begin
      in_valid  = viv[k];
      in        = vin[k];
      out_ready = vrd[k];
      tick();
      nvec++;
      if (obs !== vex[k]) begin
        nerr++;
        $display("FAIL back_to_back step %0d: got %b expected %b", k, obs, vex[k]);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_ignore();
    test_single();
    test_multi();
    test_endpoints();
    test_stall();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
